// File: rtl/execute_muldiv_seq.sv
// Iterative RV32M multiply/divide unit for the execute stage: one operand bit per cycle,
// 32 CALC cycles, then a single DONE cycle that presents the result and releases the pipeline.
module execute_muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_vld,
    input  logic [31:0] id_inst,
    input  logic [31:0] id_dat_a,
    input  logic [31:0] id_dat_b,
    input  logic        md_kill,
    output logic        md_stall,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] md_dat
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, res_q, res_d;
    logic        neg_q, neg_d, rem_neg_q, rem_neg_d, div0_q, div0_d;

    logic        mop;
    logic [2:0]  f3;
    logic        a_sgn, b_sgn;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum, div_tmp, div_diff;
    logic        div_ge;
    logic [31:0] step_hi, step_lo;
    logic [63:0] prod_fix;
    logic [31:0] quo, rem, final_res;
    logic        unused_inst_bits;

    assign unused_inst_bits = ^{id_inst[24:15], id_inst[11:7]};

    assign mop   = id_vld && (id_inst[6:0] == 7'b0110011) && (id_inst[31:25] == 7'b0000001);
    assign f3    = id_inst[14:12];
    // a is signed for MULH, MULHSU, DIV, REM; b only for MULH, DIV, REM
    assign a_sgn = id_dat_a[31] && (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b110);
    assign b_sgn = id_dat_b[31] && (f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b110);
    assign a_mag = a_sgn ? -id_dat_a : id_dat_a;
    assign b_mag = b_sgn ? -id_dat_b : id_dat_b;

    // Multiply: {hi,lo} holds partial product over the shrinking multiplier.
    // Divide:   hi is the running remainder, lo shifts out dividend bits and in quotient bits.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : 32'd0)};
        div_tmp  = {hi_q, lo_q[31]};
        div_diff = div_tmp - {1'b0, opnd_q};
        div_ge   = (div_tmp >= {1'b0, opnd_q});
        if (op_q[2]) begin
            step_hi = div_ge ? div_diff[31:0] : div_tmp[31:0];
            step_lo = {lo_q[30:0], div_ge};
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], lo_q[31:1]};
        end
        prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        quo      = div0_q ? 32'hFFFF_FFFF : (neg_q ? -step_lo : step_lo);
        rem      = rem_neg_q ? -step_hi : step_hi;
        case (op_q)
            3'b000:                 final_res = prod_fix[31:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[63:32];
            3'b100, 3'b101:         final_res = quo;
            default:                final_res = rem;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        res_d     = res_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        case (state_q)
            IDLE: begin
                if (mop && !md_kill) begin
                    state_d   = CALC;
                    cnt_d     = 5'd0;
                    op_d      = f3;
                    hi_d      = 32'd0;
                    lo_d      = f3[2] ? a_mag : b_mag;
                    opnd_d    = f3[2] ? b_mag : a_mag;
                    neg_d     = a_sgn ^ b_sgn;
                    rem_neg_d = a_sgn;
                    div0_d    = (id_dat_b == 32'd0);
                end
            end
            CALC: begin
                if (md_kill) begin
                    state_d = IDLE;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = DONE;
                        res_d   = final_res;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            op_q      <= 3'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            opnd_q    <= 32'd0;
            res_q     <= 32'd0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opnd_q    <= opnd_d;
            res_q     <= res_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
        end
    end

    // A kill in DONE suppresses the result so a flushed instruction never writes back.
    always_comb begin
        md_busy = (state_q != IDLE);
        md_done = (state_q == DONE) && !md_kill;
        md_dat  = md_done ? res_q : 32'd0;
        case (state_q)
            IDLE:    md_stall = mop && !md_kill && !rst;
            CALC:    md_stall = !md_kill;
            default: md_stall = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_execute_muldiv_seq.sv
// Randomized and directed bench for execute_muldiv_seq, checked every cycle against an
// arithmetic reference model that only knows "result appears 33 cycles after acceptance".
module tb_execute_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_vld;
    logic [31:0] id_inst;
    logic [31:0] id_dat_a;
    logic [31:0] id_dat_b;
    logic        md_kill;
    logic        md_stall;
    logic        md_busy;
    logic        md_done;
    logic [31:0] md_dat;

    int checks = 0;
    int errors = 0;

    execute_muldiv_seq dut (
        .clk      (clk),
        .rst      (rst),
        .id_vld   (id_vld),
        .id_inst  (id_inst),
        .id_dat_a (id_dat_a),
        .id_dat_b (id_dat_b),
        .md_kill  (md_kill),
        .md_stall (md_stall),
        .md_busy  (md_busy),
        .md_done  (md_done),
        .md_dat   (md_dat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mop_inst(input logic [2:0] f);
        return {7'b0000001, 5'd2, 5'd1, f, 5'd3, 7'b0110011};
    endfunction

    // Reference arithmetic from the RV32M definitions.
    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ae, be, p;
        int sa, sb;
        sa = a;
        sb = b;
        ae = {{32{a[31]}}, a};
        be = {{32{b[31]}}, b};
        case (f)
            3'd0: return a * b;
            3'd1: begin p = ae * be; return p[63:32]; end
            3'd2: begin p = ae * {32'd0, b}; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Model state: whether an op is in flight and how many cycles since acceptance.
    bit          m_inflight = 1'b0;
    int          m_age = 0;
    logic [31:0] m_res = 32'd0;
    logic        e_stall, e_busy, e_done, m_mop;
    logic [31:0] e_dat;

    always @(negedge clk) begin
        e_stall = 1'b0;
        e_busy  = 1'b0;
        e_done  = 1'b0;
        e_dat   = 32'd0;
        if (rst) begin
            m_inflight = 1'b0;
        end else if (!m_inflight) begin
            m_mop   = id_vld && id_inst[6:0] == 7'b0110011 && id_inst[31:25] == 7'b0000001;
            e_stall = m_mop && !md_kill;
            if (m_mop && !md_kill) begin
                m_inflight = 1'b1;
                m_age      = 1;
                m_res      = ref_md(id_inst[14:12], id_dat_a, id_dat_b);
            end
        end else begin
            e_busy = 1'b1;
            if (m_age <= 32) begin
                e_stall = !md_kill;
            end else begin
                e_done = !md_kill;
                e_dat  = e_done ? m_res : 32'd0;
            end
            if (md_kill || m_age == 33) m_inflight = 1'b0;
            else m_age++;
        end
        check("md_stall", {31'd0, md_stall}, {31'd0, e_stall});
        check("md_busy",  {31'd0, md_busy},  {31'd0, e_busy});
        check("md_done",  {31'd0, md_done},  {31'd0, e_done});
        check("md_dat",   md_dat, e_dat);
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        id_vld   = 1'b1;
        id_inst  = mop_inst(f);
        id_dat_a = a;
        id_dat_b = b;
        md_kill  = 1'b0;
    endtask

    // Called at posedge+1; presents the op in this cycle and returns at posedge+1 of the
    // first cycle the pipeline is free again.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int kill_at, input logic [31:0] exp);
        start_op(f, a, b);
        for (int i = 1; i <= 33; i++) begin
            @(posedge clk); #1;
            if (kill_at >= 0 && i == kill_at + 2) begin
                md_kill = 1'b0;
                id_vld  = 1'b0;
                @(negedge clk);
                check("kill_busy_next", {31'd0, md_busy}, 32'd0);
                @(posedge clk); #1;
                return;
            end
            if (i < 33) begin
                id_inst  = $urandom;
                id_dat_a = $urandom;
                id_dat_b = $urandom;
            end else begin
                id_vld = 1'b0;
            end
            if (kill_at >= 0 && i == kill_at + 1) begin
                md_kill = 1'b1;
                @(negedge clk);
                check("kill_stall", {31'd0, md_stall}, 32'd0);
            end
            if (i == 33) begin
                @(negedge clk);
                check("done_at_33", {31'd0, md_done}, 32'd1);
                check("result", md_dat, exp);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        rst      = 1'b1;
        id_vld   = 1'b0;
        id_inst  = 32'd0;
        id_dat_a = 32'd0;
        id_dat_b = 32'd0;
        md_kill  = 1'b0;

        check("pin_mul",    ref_md(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("pin_mulh",   ref_md(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        check("pin_mulhu",  ref_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("pin_div_ov", ref_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        check("pin_rem_ov", ref_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);
        check("pin_rem_neg", ref_md(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, -1, 32'hFFFF_FFEB);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, -1, 32'h4000_0000);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 32'hFFFF_FFFE);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1, 32'h8000_0000);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1, 32'd0);
        run_op(3'd5, 32'd5, 32'd0, -1, 32'hFFFF_FFFF);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd0, -1, 32'hFFFF_FFF9);

        // Kill at counter 10, then a normal op.
        run_op(3'd0, 32'd3, 32'd5, 10, 32'd0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, -1, 32'hFFFF_FFFF);

        // Non-M ops and an M-op with id_vld low are ignored.
        id_vld = 1'b1; id_inst = 32'h0020_81B3;
        @(posedge clk); #1;
        id_vld = 1'b0; id_inst = mop_inst(3'd0);
        @(posedge clk); #1;
        // Kill coinciding with an IDLE decode is not accepted.
        start_op(3'd0, 32'd9, 32'd9);
        md_kill = 1'b1;
        @(posedge clk); #1;
        md_kill = 1'b0; id_vld = 1'b0;
        @(negedge clk);
        check("kill_idle_busy", {31'd0, md_busy}, 32'd0);
        @(posedge clk); #1;

        // Reset mid-CALC, then back-to-back ops from the first post-reset edge.
        start_op(3'd4, 32'd100, 32'd7);
        @(posedge clk); #1;
        id_vld = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_busy",  {31'd0, md_busy},  32'd0);
        check("rst_stall", {31'd0, md_stall}, 32'd0);
        check("rst_done",  {31'd0, md_done},  32'd0);
        check("rst_dat",   md_dat, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(3'd0, 32'd6, 32'd7, -1, 32'd42);
        run_op(3'd7, 32'd100, 32'd7, -1, 32'd2);

        for (int n = 0; n < 40; n++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            if ($urandom_range(0, 5) == 0)
                run_op(f, a, b, int'($urandom_range(0, 31)), 32'd0);
            else
                run_op(f, a, b, -1, ref_md(f, a, b));
            if ($urandom_range(0, 3) == 0) begin
                id_vld = 1'b1; id_inst = $urandom & 32'hFDFF_FFFF;
                @(posedge clk); #1;
                id_vld = 1'b0;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_muldiv_seq.md
EXECUTE_MULDIV_SEQ -- requirements
Module: execute_muldiv_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port id_vld, input, 1 bit: id_inst/operands in execute are valid.
REQ-004 SHALL have port id_inst, input, 32 bits: execute-stage instruction.
REQ-005 SHALL have port id_dat_a, input, 32 bits: operand rs1 (forwarded value).
REQ-006 SHALL have port id_dat_b, input, 32 bits: operand rs2 (forwarded value).
REQ-007 SHALL have port md_kill, input, 1 bit: abort the in-flight operation (trap/flush).
REQ-008 SHALL have port md_stall, output, 1 bit: hold fetch/decode/execute registers.
REQ-009 SHALL have port md_busy, output, 1 bit: sequencer not in IDLE.
REQ-010 SHALL have port md_done, output, 1 bit: single-cycle pulse, md_dat valid.
REQ-011 SHALL have port md_dat, output, 32 bits: multiply/divide result for the memory-access stage.

Function
REQ-012 SHALL decode an M-op when id_vld=1, id_inst[6:0]=0110011 and id_inst[31:25]=0000001.
REQ-013 SHALL select the operation by funct3 id_inst[14:12]: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-014 SHALL implement three states: IDLE, CALC and DONE.
REQ-015 SHALL transition IDLE->CALC when an M-op is decoded and md_kill=0, latching op, operand magnitudes and result sign, and clearing the 5-bit iteration counter.
REQ-016 SHALL, in CALC, process one operand bit per cycle for exactly 32 cycles (counter 0..31), transitioning CALC->DONE when counter=31.
REQ-017 SHALL transition DONE->IDLE unconditionally after one cycle.
REQ-018 SHALL implement multiply as a 32-iteration shift-add on magnitudes into a 64-bit product; MULH treats both operands as signed, MULHSU treats a as signed and b as unsigned, MULHU/MUL treat both as unsigned-magnitude.
REQ-019 SHALL negate the 64-bit product when the signed operand signs differ.
REQ-020 SHALL return the low 32 bits of the product for MUL and the high 32 bits for MULH/MULHSU/MULHU.
REQ-021 SHALL implement divide as a 32-iteration restoring division on magnitudes; DIV/REM are signed, DIVU/REMU unsigned.
REQ-022 SHALL negate the quotient when the dividend and divisor signs differ, and SHALL give the remainder the dividend's sign.
REQ-023 SHALL, when the divisor is 0, return quotient 0xFFFFFFFF (no sign fix) and remainder = id_dat_a, still taking 32 CALC cycles.
REQ-024 SHALL return quotient 0x80000000 and remainder 0 for signed overflow 0x80000000 / 0xFFFFFFFF.
REQ-025 SHALL drive md_stall combinationally high in IDLE while an M-op is decoded, and high throughout CALC.
REQ-026 SHALL drive md_stall low in DONE so the pipeline advances exactly one instruction carrying md_dat.
REQ-027 SHALL drive md_done=1 only in DONE, with md_dat held at the final result; md_dat=0 whenever md_done=0.
REQ-028 SHALL give a latency where acceptance in cycle N produces md_done in cycle N+33, with md_stall high for cycles N..N+32.
REQ-029 SHALL drive md_busy=1 in CALC and DONE.
REQ-030 SHALL, when md_kill=1 in CALC or DONE, transition to IDLE on the next edge, produce no md_done, and deassert md_stall combinationally in the kill cycle.
REQ-031 SHALL NOT accept an operation when md_kill=1 coincides with an IDLE decode; md_stall stays 0 in that cycle.
REQ-032 SHALL ignore id_inst/id_dat_a/id_dat_b changes during CALC and use only latched values.
REQ-033 SHALL ignore non-M-ops: md_stall=0 and state stays IDLE.

Reset
REQ-034 SHALL, while rst=1, immediately force state=IDLE, counter=0, all datapath registers=0, and md_stall=md_busy=md_done=0, md_dat=0.
REQ-035 SHALL abandon any operation in flight when rst asserts mid-CALC, and SHALL produce no md_done after rst deasserts.
REQ-036 SHALL accept a new M-op on the first clock edge after rst deasserts.

Verification
REQ-037 SHALL be verified with MUL a=7, b=0xFFFFFFFD accepted at cycle N -> md_done at N+33, md_dat=0xFFFFFFEB, md_stall high N..N+32.
REQ-038 SHALL be verified with MULH a=b=0x80000000 -> md_dat=0x40000000; MULHU a=b=0xFFFFFFFF -> md_dat=0xFFFFFFFE.
REQ-039 SHALL be verified with DIV 0x80000000/0xFFFFFFFF -> md_dat=0x80000000; REM of the same operands -> md_dat=0.
REQ-040 SHALL be verified with DIVU 5/0 -> md_dat=0xFFFFFFFF; REM 0xFFFFFFF9/0 -> md_dat=0xFFFFFFF9; both at N+33.
REQ-041 SHALL be verified with md_kill pulsed at CALC counter=10 -> md_stall low that cycle, md_busy low next cycle, no md_done; the next M-op completes normally.
REQ-042 SHALL be verified with rst asserted mid-CALC -> all outputs 0 immediately; back-to-back M-ops after reset complete at N+33 and N+34+33.
